mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto one shared memory port, one transaction at a time.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_fu_req/i_fu_addr             fetch read request and word address
//   o_fu_gnt                       fetch accept pulse
//   o_fu_rvalid/o_fu_rdata         fetch response pulse and instruction word
//   i_mau_req/_we/_addr/_wdata/_len data request fields (len: 0 byte, 1 half, 2 word)
//   o_mau_gnt                      data accept pulse
//   o_mau_rvalid/o_mau_rdata       data response pulse and read data (0 for writes)
//   i_flush                        cancels fetch traffic
//   o_mem_valid/_we/_addr/_wdata/_len  shared memory request, fields zero when not valid
//   i_mem_ready                    memory accepts request
//   i_mem_rvalid/i_mem_rdata       memory response
//   o_busy                         high whenever not IDLE
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_fu_req,
    input  logic [31:0] i_fu_addr,
    output logic        o_fu_gnt,
    output logic        o_fu_rvalid,
    output logic [31:0] o_fu_rdata,
    input  logic        i_mau_req,
    input  logic        i_mau_we,
    input  logic [31:0] i_mau_addr,
    input  logic [31:0] i_mau_wdata,
    input  logic [1:0]  i_mau_len,
    output logic        o_mau_gnt,
    output logic        o_mau_rvalid,
    output logic [31:0] o_mau_rdata,
    input  logic        i_flush,
    output logic        o_mem_valid,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_len,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t      state, state_nx;
    logic [3:0]  starve_cnt;
    logic        owner_fu, cancel, lat_we;
    logic [31:0] lat_addr, lat_wdata, fu_rdata_q, mau_rdata_q;
    logic [1:0]  lat_len;
    logic        fu_elig, pick_fu, pick_mau, resp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        fu_elig      = i_fu_req && !i_flush;
        pick_fu      = fu_elig && (!i_mau_req || starve_cnt == LIMIT);
        pick_mau     = i_mau_req && !pick_fu;
        // gnt is gated by rstn so no pulse escapes while reset holds the FSM in IDLE
        o_fu_gnt     = rstn && state == IDLE && pick_fu;
        o_mau_gnt    = rstn && state == IDLE && pick_mau;
        resp         = state == WAIT && i_mem_rvalid;
        // a flush coinciding with the response also suppresses it
        o_fu_rvalid  = resp && owner_fu && !cancel && !i_flush;
        o_mau_rvalid = resp && !owner_fu;
        o_fu_rdata   = o_fu_rvalid ? i_mem_rdata : fu_rdata_q;
        o_mau_rdata  = o_mau_rvalid ? (lat_we ? 32'd0 : i_mem_rdata) : mau_rdata_q;
        o_mem_valid  = state == ISSUE;
        o_mem_we     = o_mem_valid && lat_we;
        o_mem_addr   = o_mem_valid ? lat_addr : 32'd0;
        o_mem_wdata  = o_mem_valid ? lat_wdata : 32'd0;
        o_mem_len    = o_mem_valid ? lat_len : 2'd0;
        o_busy       = state != IDLE;
        state_nx     = state;
        case (state)
            IDLE:    state_nx = (o_fu_gnt || o_mau_gnt) ? ISSUE : IDLE;
            ISSUE:   state_nx = i_mem_ready ? WAIT : ISSUE;
            WAIT:    state_nx = i_mem_rvalid ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt  <= '0;
            cancel      <= 1'b0;
            owner_fu    <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_len     <= '0;
            fu_rdata_q  <= '0;
            mau_rdata_q <= '0;
        end else begin
            if (o_fu_gnt || o_mau_gnt) begin
                owner_fu   <= pick_fu;
                lat_we     <= pick_mau && i_mau_we;
                lat_addr   <= pick_fu ? i_fu_addr : i_mau_addr;
                lat_wdata  <= pick_fu ? 32'd0 : i_mau_wdata;
                lat_len    <= pick_fu ? 2'd2 : i_mau_len;
                starve_cnt <= (o_fu_gnt || !fu_elig) ? 4'd0 :
                              (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            end
            if (state == IDLE || resp) cancel <= 1'b0;
            else if (owner_fu && i_flush) cancel <= 1'b1;
            if (o_fu_rvalid) fu_rdata_q <= o_fu_rdata;
            if (o_mau_rvalid) mau_rdata_q <= o_mau_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        i_fu_req = 1'b0, i_mau_req = 1'b0, i_mau_we = 1'b0, i_flush = 1'b0;
    logic        i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
    logic [31:0] i_fu_addr = '0, i_mau_addr = '0, i_mau_wdata = '0, i_mem_rdata = '0;
    logic [1:0]  i_mau_len = '0;
    logic        o_fu_gnt, o_fu_rvalid, o_mau_gnt, o_mau_rvalid, o_mem_valid, o_mem_we, o_busy;
    logic [31:0] o_fu_rdata, o_mau_rdata, o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_len;
    int          errors = 0, checks = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_fu_req(i_fu_req), .i_fu_addr(i_fu_addr), .o_fu_gnt(o_fu_gnt),
        .o_fu_rvalid(o_fu_rvalid), .o_fu_rdata(o_fu_rdata),
        .i_mau_req(i_mau_req), .i_mau_we(i_mau_we), .i_mau_addr(i_mau_addr),
        .i_mau_wdata(i_mau_wdata), .i_mau_len(i_mau_len), .o_mau_gnt(o_mau_gnt),
        .o_mau_rvalid(o_mau_rvalid), .o_mau_rdata(o_mau_rdata), .i_flush(i_flush),
        .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_len(o_mem_len), .i_mem_ready(i_mem_ready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        logic exp_f;
        int   cnt;
        // reset holds everything quiet even with a request present
        i_fu_req = 1'b1;
        tick; tick; settle;
        chk("rst_fu_gnt", 32'(o_fu_gnt), 0);
        chk("rst_mem_valid", 32'(o_mem_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_fu_rdata", o_fu_rdata, 0);
        chk("rst_mau_rdata", o_mau_rdata, 0);
        i_fu_req = 1'b0;
        rstn = 1'b1;
        // fetch only
        tick;
        i_fu_req = 1'b1; i_fu_addr = 32'h100; settle;
        chk("f_gnt", 32'(o_fu_gnt), 1);
        chk("f_mau_gnt", 32'(o_mau_gnt), 0);
        chk("f_c0_valid", 32'(o_mem_valid), 0);
        tick;
        i_fu_req = 1'b0; i_mem_ready = 1'b1; settle;
        chk("f_c1_valid", 32'(o_mem_valid), 1);
        chk("f_c1_addr", o_mem_addr, 32'h100);
        chk("f_c1_we", 32'(o_mem_we), 0);
        chk("f_c1_busy", 32'(o_busy), 1);
        tick;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h13; settle;
        chk("f_c2_rvalid", 32'(o_fu_rvalid), 1);
        chk("f_c2_rdata", o_fu_rdata, 32'h13);
        chk("f_c2_mau_rvalid", 32'(o_mau_rvalid), 0);
        tick;
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'h55; settle;
        chk("f_c3_rvalid", 32'(o_fu_rvalid), 0);
        chk("f_c3_rdata_hold", o_fu_rdata, 32'h13);
        chk("f_c3_busy", 32'(o_busy), 0);
        // data write with a stalled memory
        i_mau_req = 1'b1; i_mau_we = 1'b1; i_mau_addr = 32'h2000;
        i_mau_wdata = 32'hDEADBEEF; i_mau_len = 2'd2; settle;
        chk("w_gnt", 32'(o_mau_gnt), 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            i_mau_req = 1'b0; i_mau_we = 1'b0; i_mau_addr = '0; i_mau_wdata = '0; i_mau_len = '0;
            i_mem_ready = (i == 3); settle;
            chk("w_valid", 32'(o_mem_valid), 1);
            chk("w_we", 32'(o_mem_we), 1);
            chk("w_addr", o_mem_addr, 32'h2000);
            chk("w_wdata", o_mem_wdata, 32'hDEADBEEF);
            chk("w_len", 32'(o_mem_len), 2);
        end
        tick;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234; settle;
        chk("w_valid_off", 32'(o_mem_valid), 0);
        chk("w_mau_rvalid", 32'(o_mau_rvalid), 1);
        chk("w_mau_rdata", o_mau_rdata, 0);
        chk("w_fu_rvalid", 32'(o_fu_rvalid), 0);
        tick;
        i_mem_rvalid = 1'b0; settle;
        chk("w_idle_addr", o_mem_addr, 0);
        chk("w_idle_rvalid", 32'(o_mau_rvalid), 0);
        // both requesters held continuously; ready/rvalid held high too
        i_fu_req = 1'b1; i_fu_addr = 32'h500;
        i_mau_req = 1'b1; i_mau_addr = 32'h4000; i_mau_len = 2'd2;
        i_mem_ready = 1'b1; i_mem_rvalid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            i_mem_rdata = 32'h1000 + 32'(k);
            exp_f = (cnt == 4);
            cnt = exp_f ? 0 : cnt + 1;
            settle;
            chk($sformatf("s%0d_fu_gnt", k), 32'(o_fu_gnt), 32'(exp_f));
            chk($sformatf("s%0d_mau_gnt", k), 32'(o_mau_gnt), 32'(!exp_f));
            tick;
            chk($sformatf("s%0d_starve", k), 32'(dut.starve_cnt), 32'(cnt));
            chk($sformatf("s%0d_issue_nogrant", k), 32'(o_fu_gnt | o_mau_gnt), 0);
            chk($sformatf("s%0d_addr", k), o_mem_addr, exp_f ? 32'h500 : 32'h4000);
            tick;
            chk($sformatf("s%0d_fu_rvalid", k), 32'(o_fu_rvalid), 32'(exp_f));
            chk($sformatf("s%0d_mau_rvalid", k), 32'(o_mau_rvalid), 32'(!exp_f));
            chk($sformatf("s%0d_rdata", k), exp_f ? o_fu_rdata : o_mau_rdata, 32'h1000 + 32'(k));
            tick;
        end
        i_fu_req = 1'b0; i_mau_req = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
        // flush while a fetch waits for memory
        tick;
        i_fu_req = 1'b1; i_fu_addr = 32'h200; settle;
        chk("fl_gnt", 32'(o_fu_gnt), 1);
        tick;
        i_fu_req = 1'b0; i_mem_ready = 1'b1; settle;
        chk("fl_valid", 32'(o_mem_valid), 1);
        tick;
        i_mem_ready = 1'b0; i_flush = 1'b1; settle;
        chk("fl_wait_busy", 32'(o_busy), 1);
        tick;
        i_flush = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77; settle;
        chk("fl_suppressed", 32'(o_fu_rvalid), 0);
        chk("fl_rdata_hold", o_fu_rdata, 32'h1009);
        tick;
        i_mem_rvalid = 1'b0; i_fu_req = 1'b1; i_fu_addr = 32'h300; settle;
        chk("fl_idle", 32'(o_busy), 0);
        chk("fl_new_gnt", 32'(o_fu_gnt), 1);
        tick;
        i_fu_req = 1'b0; i_mem_ready = 1'b1;
        tick;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h99; settle;
        chk("fl_new_rvalid", 32'(o_fu_rvalid), 1);
        chk("fl_new_rdata", o_fu_rdata, 32'h99);
        tick;
        // fetch blocked by a flush in the same cycle
        i_mem_rvalid = 1'b0; i_fu_req = 1'b1; i_fu_addr = 32'h400; i_flush = 1'b1; settle;
        chk("ff_no_gnt", 32'(o_fu_gnt), 0);
        tick;
        i_flush = 1'b0; settle;
        chk("ff_gnt", 32'(o_fu_gnt), 1);
        tick;
        i_fu_req = 1'b0; i_mem_ready = 1'b1;
        tick;
        i_mem_ready = 1'b0; settle;
        chk("rw_busy", 32'(o_busy), 1);
        // reset during WAIT abandons the transaction
        rstn = 1'b0; settle;
        chk("rw_busy0", 32'(o_busy), 0);
        chk("rw_rdata0", o_fu_rdata, 0);
        chk("rw_valid0", 32'(o_mem_valid), 0);
        tick;
        rstn = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAA;
        i_mau_req = 1'b1; i_mau_we = 1'b0; i_mau_addr = 32'h80; settle;
        chk("rw_fu_rvalid", 32'(o_fu_rvalid), 0);
        chk("rw_mau_rvalid", 32'(o_mau_rvalid), 0);
        chk("rw_first_gnt", 32'(o_mau_gnt), 1);
        tick;
        i_mau_req = 1'b0; i_mem_rvalid = 1'b0; settle;
        chk("rw_issue_addr", o_mem_addr, 32'h80);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
